// File: rtl/rv_pipe_arbiter_if.sv
// Request/response bundle for rv_pipe_arbiter.
// The req_lock port exists only when RV_PIPE_ARB_LOCK_EN is defined.
interface rv_pipe_arbiter_if #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  parameter int TAGW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
);
  logic [NUM_REQS-1:0]       req_valid;
  logic [NUM_REQS*DATAW-1:0] req_data;
  logic [NUM_REQS-1:0]       req_ready;
`ifdef RV_PIPE_ARB_LOCK_EN
  logic [NUM_REQS-1:0]       req_lock;
`endif
  logic                      rsp_valid;
  logic [DATAW-1:0]          rsp_data;
  logic [TAGW-1:0]           rsp_tag;
  logic                      rsp_ready;

`ifdef RV_PIPE_ARB_LOCK_EN
  modport master (output req_valid, req_data, req_lock, rsp_ready,
                  input  req_ready, rsp_valid, rsp_data, rsp_tag);
  modport slave  (input  req_valid, req_data, req_lock, rsp_ready,
                  output req_ready, rsp_valid, rsp_data, rsp_tag);
`else
  modport master (output req_valid, req_data, rsp_ready,
                  input  req_ready, rsp_valid, rsp_data, rsp_tag);
  modport slave  (input  req_valid, req_data, rsp_ready,
                  output req_ready, rsp_valid, rsp_data, rsp_tag);
`endif
endinterface

// File: rtl/rv_pipe_arbiter.sv
// Round-robin arbiter feeding a DEPTH-stage shared pipe with a global stall.
// Optional burst locking is enabled with RV_PIPE_ARB_LOCK_EN.
module rv_pipe_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  parameter int DEPTH    = 2
) (
  input  logic           clk,
  input  logic           reset,
  rv_pipe_arbiter_if.slave bus
);
  localparam int TAGW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  function automatic logic [TAGW-1:0] inc_mod(input logic [TAGW-1:0] w);
    if (int'(w) >= NUM_REQS - 1) return '0;
    else return w + TAGW'(1);
  endfunction

  logic                enable;
  logic                found;
  logic                accept;
  logic [TAGW-1:0]     winner;
  logic [TAGW-1:0]     base;
  logic [NUM_REQS-1:0] grant;
  int                  idx;

  logic [TAGW-1:0]     ptr_q, ptr_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DATAW-1:0]    data_q [DEPTH];
  logic [DATAW-1:0]    data_d [DEPTH];
  logic [TAGW-1:0]     tag_q  [DEPTH];
  logic [TAGW-1:0]     tag_d  [DEPTH];

`ifdef RV_PIPE_ARB_LOCK_EN
  logic                lock_q, lock_d;
  logic [TAGW-1:0]     owner_q, owner_d;
  logic                owner_valid;
`endif

  // Arbitration: search upward from base, wrapping; an active lock overrides.
  always_comb begin
    enable = ~(valid_q[DEPTH-1] & ~bus.rsp_ready);
    base   = ptr_q;
`ifdef RV_PIPE_ARB_LOCK_EN
    owner_valid = lock_q & bus.req_valid[owner_q];
    if (lock_q && !owner_valid) base = inc_mod(owner_q);
`endif
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NUM_REQS; i++) begin
      idx = int'(base) + i;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = TAGW'(idx);
      end
    end
`ifdef RV_PIPE_ARB_LOCK_EN
    if (owner_valid) begin
      found  = 1'b1;
      winner = owner_q;
    end
`endif
    grant = '0;
    if (found) grant[winner] = 1'b1;
    bus.req_ready = grant & {NUM_REQS{enable}};
    accept = found & enable;
  end

  always_comb begin
    ptr_d = ptr_q;
`ifdef RV_PIPE_ARB_LOCK_EN
    lock_d  = lock_q;
    owner_d = owner_q;
    if (accept) begin
      if (bus.req_lock[winner]) begin
        lock_d  = 1'b1;
        owner_d = winner;
      end else begin
        lock_d = 1'b0;
        ptr_d  = inc_mod(winner);
      end
    end else if (enable && lock_q) begin
      // Owner dropped valid and nobody else was waiting: release anyway.
      lock_d = 1'b0;
      ptr_d  = inc_mod(owner_q);
    end
`else
    if (accept) ptr_d = inc_mod(winner);
`endif
  end

  // Pipe shifts as a whole on enable; holds everything on stall.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (enable) begin
      valid_d[0] = found;
      data_d[0]  = bus.req_data[int'(winner)*DATAW +: DATAW];
      tag_d[0]   = winner;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = data_q[k-1];
        tag_d[k]   = tag_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      ptr_q   <= '0;
`ifdef RV_PIPE_ARB_LOCK_EN
      lock_q  <= 1'b0;
      owner_q <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
`ifdef RV_PIPE_ARB_LOCK_EN
      lock_q  <= lock_d;
      owner_q <= owner_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  assign bus.rsp_valid = valid_q[DEPTH-1];
  assign bus.rsp_data  = data_q[DEPTH-1];
  assign bus.rsp_tag   = tag_q[DEPTH-1];
endmodule

// File: tb/tb_rv_pipe_arbiter.sv
// Directed bench for rv_pipe_arbiter (NUM_REQS=4, DATAW=32, DEPTH=2).
// The lock-burst sequence runs only when RV_PIPE_ARB_LOCK_EN is defined.
module tb_rv_pipe_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic [31:0] dat [4];

  always #5 clk = ~clk;

  rv_pipe_arbiter_if #(.NUM_REQS(4), .DATAW(32), .TAGW(2)) bus ();

  rv_pipe_arbiter #(.NUM_REQS(4), .DATAW(32), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One cycle: drive, check combinational grant and registered response, advance.
  task automatic step(input logic [3:0] v, input logic rr, input logic [3:0] lk,
                      input logic [3:0] exp_rdy, input logic exp_rv, input int exp_tag);
    bus.req_valid = v;
    bus.rsp_ready = rr;
`ifdef RV_PIPE_ARB_LOCK_EN
    bus.req_lock  = lk;
`endif
    @(negedge clk);
    cyc++;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rsp_tag", 32'(bus.rsp_tag), 32'(exp_tag));
      chk("rsp_data", bus.rsp_data, dat[exp_tag]);
    end
    $display("cyc %0d rst=%b v=%b lk=%b rr=%b ready=%b rsp_valid=%b tag=%0d data=%h",
             cyc, reset, v, lk, rr, bus.req_ready, bus.rsp_valid, bus.rsp_tag, bus.rsp_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    dat[0] = 32'h1000_0001;
    dat[1] = 32'h2222_2222;
    dat[2] = 32'hA5A5_A5A5;
    dat[3] = 32'h3C3C_3C3C;
    bus.req_data  = {dat[3], dat[2], dat[1], dat[0]};
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
`ifdef RV_PIPE_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single request from requester 2, visible two cycles after its grant.
    step(4'b0100, 1'b1, 4'b0000, 4'b0100, 1'b0, 0);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 0);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 2);
    // Pointer=3: wrap to 0, then 1, then pointer=2 picks 2 over 0.
    step(4'b0011, 1'b1, 4'b0000, 4'b0001, 1'b0, 0);
    step(4'b0010, 1'b1, 4'b0000, 4'b0010, 1'b0, 0);
    step(4'b0101, 1'b1, 4'b0000, 4'b0100, 1'b1, 0);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1);
    step(4'b1000, 1'b1, 4'b0000, 4'b1000, 1'b1, 2);
    step(4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b0, 0);
    // Reset with tags 3 and 0 in flight: neither may appear afterwards.
    reset = 1'b0;
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 3);
    reset = 1'b1;
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 0);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 0);
    // All valid from pointer 0: grants 0,1,2,3,0.
    step(4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b0, 0);
    step(4'b1111, 1'b1, 4'b0000, 4'b0010, 1'b0, 0);
    step(4'b1111, 1'b1, 4'b0000, 4'b0100, 1'b1, 0);
    step(4'b1111, 1'b1, 4'b0000, 4'b1000, 1'b1, 1);
    step(4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b1, 2);
    // Fill the pipe with two tag-1 beats, then stall three cycles.
    step(4'b1111, 1'b1, 4'b0000, 4'b0010, 1'b1, 3);
    step(4'b0010, 1'b1, 4'b0000, 4'b0010, 1'b1, 0);
    step(4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1, 1);
    step(4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1, 1);
    step(4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1, 1);
    step(4'b1111, 1'b1, 4'b0000, 4'b0100, 1'b1, 1);
    step(4'b1111, 1'b1, 4'b0000, 4'b1000, 1'b1, 1);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 2);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 3);
    // rsp_ready low with an empty output stage is not a stall.
    step(4'b0001, 1'b0, 4'b0000, 4'b0001, 1'b0, 0);
    step(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 0);
    step(4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1, 0);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 0);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 0);
`ifdef RV_PIPE_ARB_LOCK_EN
    // Pointer=1: burst 1,1,1 (lock 1,1,0), then 2, then 0.
    step(4'b0111, 1'b1, 4'b0010, 4'b0010, 1'b0, 0);
    step(4'b0111, 1'b1, 4'b0010, 4'b0010, 1'b0, 0);
    step(4'b0111, 1'b1, 4'b0000, 4'b0010, 1'b1, 1);
    step(4'b0101, 1'b1, 4'b0000, 4'b0100, 1'b1, 1);
    step(4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b1, 1);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 2);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 0);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_pipe_arbiter.md
Name: rv_pipe_arbiter

Overview:
- Round-robin arbiter that shares one DEPTH-stage pipelined datapath among NUM_REQS requesters.
- Owns the valid bits, per-stage tags and global stall of the shared pipe.
- Returns results on a single valid/ready response port, tagged with the requester index.
- Sits between per-warp/per-lane issue ports and a shared multi-cycle functional unit.

Parameters:
- NUM_REQS, 4, number of requesters (>=1).
- DATAW, 32, payload width per requester.
- DEPTH, 2, pipeline stages between acceptance and response (>=1).
- TAGW, (NUM_REQS>1 ? $clog2(NUM_REQS) : 1), requester tag width; derived, not overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  reset. Single clock domain; reset is synchronous and active-low, asserted when 0, sampled on posedge clk.
- req_valid  in  NUM_REQS  per-requester request valid.
- req_data  in  NUM_REQS*DATAW  payloads; requester i occupies bits [i*DATAW +: DATAW].
- req_ready  out  NUM_REQS  per-requester accept; one-hot or zero.
- rsp_valid  out  1  response valid (last stage valid).
- rsp_data  out  DATAW  response payload.
- rsp_tag  out  TAGW  index of the originating requester.
- rsp_ready  in  1  downstream accept.

Behaviour:
- Reset (reset==0):
  - All stage valid bits clear, so rsp_valid=0 in the cycle after the reset edge.
  - Round-robin pointer = 0.
  - Stage data/tag registers are not reset; rsp_data and rsp_tag are don't-care while rsp_valid=0.
  - Reset mid-operation discards all in-flight entries and requires no handshake.
- stall = rsp_valid & ~rsp_ready.
- enable = ~stall. Every stage advances only when enable=1; the whole pipe freezes on stall. There is no bubble collapsing.
- Arbitration (combinational):
  - Search req_valid starting at pointer, upward, wrapping modulo NUM_REQS.
  - The first set bit is the winner, grant = onehot(winner).
- req_ready = grant & {NUM_REQS{enable}}.
- Handshake: requester i is accepted when req_valid[i] & req_ready[i]. Requesters must hold req_valid and req_data stable until accepted.
- Stage 0 capture, when enable=1:
  - valid0 = |req_valid.
  - data0 = the winner's data; tag0 = the winner index.
  - If no request, valid0=0 and data/tag are don't-care.
- Stages k=1..DEPTH-1, when enable=1: stage k takes stage k-1 (valid, data, tag).
- The last stage drives rsp_valid, rsp_data and rsp_tag.
- Pointer update: on an accepted handshake to requester w, pointer <= (w+1) mod NUM_REQS. Unchanged on stall or when idle.
- Latency: with rsp_ready held 1, a request accepted at edge t appears with rsp_valid=1 after edge t+DEPTH-1. Equivalently, it is visible DEPTH cycles after the req_ready cycle. Throughput is 1 per cycle.
- Response ordering is strict acceptance order, because the pipe is FIFO.
- Simultaneous events:
  - A stall freezes arbitration: req_ready=0, so no acceptance that cycle.
  - A response pop and a new accept occur in the same cycle when rsp_ready=1.
- NUM_REQS=1: the pointer stays 0 and rsp_tag=0.
- No combinational path from req_valid to rsp_*. The path rsp_ready -> req_ready is combinational, which is allowed.

Optional Feature:
- Macro: RV_PIPE_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock [NUM_REQS].
  - If requester w is accepted with req_lock[w]=1, then next cycle the arbiter grants w exclusively, provided req_valid[w]=1, regardless of pointer. This gives burst ownership.
  - The pointer does not advance on a locked accept.
  - The lock releases on the first accepted beat with req_lock[w]=0, or when w drops req_valid. The pointer then becomes (w+1) mod NUM_REQS.
  - The lock state is cleared by reset and is held across stall.
- Undefined: no req_lock port; pure round-robin as above.

Test Plan:
1. Reset then single request: reset=0 for 2 cycles, release; req_valid=4'b0100, data2=0xA5A5A5A5, rsp_ready=1 -> req_ready=4'b0100 for one cycle. DEPTH=2 cycles later: rsp_valid=1, rsp_data=0xA5A5A5A5, rsp_tag=2.
2. Round-robin fairness: all four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,1,... One per cycle; rsp_tag sequence 0,1,2,3 starting 2 cycles later.
3. Backpressure: pipe full (rsp_valid=1, tag 1) with rsp_ready=0 for 3 cycles -> req_ready=0000, rsp_data/tag held and pointer held. After rsp_ready=1, the next grant is requester 2 and the stream resumes without loss or duplication.
4. Wrap and skip: pointer=3, req_valid=4'b0011 -> grant requester 0, then requester 1, then pointer=2.
5. Reset mid-operation: 2 entries in flight, assert reset=0 for one cycle -> rsp_valid=0 the next cycle, the old entries never appear, and the pointer returns to 0.
6. (RV_PIPE_ARB_LOCK_EN) Lock burst: requester 1 sends 3 beats with req_lock=1,1,0 while requesters 0 and 2 are valid -> grants 1,1,1, then requester 2, then requester 0.
